// File: rtl/day_of_year_date.sv
// Two-digit BCD day counter (00..99) feeding a combinational day-of-year to
// month/day converter; sw[0] selects the leap-year calendar.
module day_of_year_date (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] sw,
    output logic [3:0] count_msb,
    output logic [3:0] count_lsb,
    output logic [4:0] dd,
    output logic [3:0] dd_msb,
    output logic [3:0] dd_lsb,
    output logic [3:0] mm,
    output logic [3:0] mm_msb
);

    logic [3:0] count_msb_q, count_msb_d;
    logic [3:0] count_lsb_q, count_lsb_d;
    logic [3:0] msb_s, lsb_s;
    logic [6:0] doy;
    logic [6:0] feb_end, mar_end;
    logic       leap;
    logic       unused_sw;

    assign unused_sw = ^sw[9:1];
    assign leap      = sw[0];

    // Out-of-range digits are unreachable but folded to 0 so neither the
    // next count nor the date outputs can ever leave their legal range.
    always_comb begin
        msb_s = (count_msb_q > 4'd9) ? 4'd0 : count_msb_q;
        lsb_s = (count_lsb_q > 4'd9) ? 4'd0 : count_lsb_q;
    end

    always_comb begin
        count_msb_d = msb_s;
        count_lsb_d = lsb_s + 4'd1;
        if (lsb_s == 4'd9) begin
            count_lsb_d = 4'd0;
            count_msb_d = (msb_s == 4'd9) ? 4'd0 : msb_s + 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_msb_q <= 4'd0;
            count_lsb_q <= 4'd0;
        end else begin
            count_msb_q <= count_msb_d;
            count_lsb_q <= count_lsb_d;
        end
    end

    assign count_msb = count_msb_q;
    assign count_lsb = count_lsb_q;

    // Day of year is count + 1, so count 00 is Jan 1.
    assign doy     = 7'(msb_s) * 7'd10 + 7'(lsb_s) + 7'd1;
    assign feb_end = leap ? 7'd60 : 7'd59;
    assign mar_end = leap ? 7'd91 : 7'd90;

    always_comb begin
        mm = 4'd1;
        dd = 5'(doy);
        if (doy > mar_end) begin
            mm = 4'd4;
            dd = 5'(doy - mar_end);
        end else if (doy > feb_end) begin
            mm = 4'd3;
            dd = 5'(doy - feb_end);
        end else if (doy > 7'd31) begin
            mm = 4'd2;
            dd = 5'(doy - 7'd31);
        end
    end

    always_comb begin
        dd_msb = 4'd0;
        dd_lsb = 4'(dd);
        if (dd >= 5'd30) begin
            dd_msb = 4'd3;
            dd_lsb = 4'(dd - 5'd30);
        end else if (dd >= 5'd20) begin
            dd_msb = 4'd2;
            dd_lsb = 4'(dd - 5'd20);
        end else if (dd >= 5'd10) begin
            dd_msb = 4'd1;
            dd_lsb = 4'(dd - 5'd10);
        end
    end

    // Only Jan..Apr are reachable, so the month tens digit is always zero.
    assign mm_msb = 4'd0;

endmodule

// File: tb/tb_day_of_year_date.sv
// Scoreboard bench: a day-count model with a month-length table predicts
// every output; predictions are queued on each edge and popped when sampled.
module tb_day_of_year_date;

    logic       clock;
    logic       reset;
    logic [9:0] sw;
    logic [3:0] count_msb, count_lsb;
    logic [4:0] dd;
    logic [3:0] dd_msb, dd_lsb, mm, mm_msb;

    day_of_year_date dut (
        .clock    (clock),
        .reset    (reset),
        .sw       (sw),
        .count_msb(count_msb),
        .count_lsb(count_lsb),
        .dd       (dd),
        .dd_msb   (dd_msb),
        .dd_lsb   (dd_lsb),
        .mm       (mm),
        .mm_msb   (mm_msb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int cnt;
        int mon;
        int day;
        string tag;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   model_n = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void date_of(input int n, input bit lp, output int m, output int d);
        int len[4];
        len[0] = 31;
        len[1] = lp ? 29 : 28;
        len[2] = 31;
        len[3] = 30;
        d = n + 1;
        m = 1;
        while (m < 4 && d > len[m-1]) begin
            d -= len[m-1];
            m++;
        end
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        int m, d;
        date_of(model_n, sw[0], m, d);
        e.cnt = model_n;
        e.mon = m;
        e.day = d;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_empty", 0, 1);
            return;
        end
        e = sbq.pop_front();
        chk({e.tag, ".count_msb"}, int'(count_msb), e.cnt / 10);
        chk({e.tag, ".count_lsb"}, int'(count_lsb), e.cnt % 10);
        chk({e.tag, ".mm"},        int'(mm),        e.mon);
        chk({e.tag, ".mm_msb"},    int'(mm_msb),    e.mon / 10);
        chk({e.tag, ".dd"},        int'(dd),        e.day);
        chk({e.tag, ".dd_msb"},    int'(dd_msb),    e.day / 10);
        chk({e.tag, ".dd_lsb"},    int'(dd_lsb),    e.day % 10);
    endtask

    task automatic step(input bit rst, input string tag);
        reset = rst;
        @(posedge clock);
        model_n = rst ? 0 : (model_n + 1) % 100;
        push_exp(tag);
        #1;
        pop_cmp();
    endtask

    task automatic set_leap(input bit lp, input string tag);
        sw[0] = lp;
        #1;
        push_exp(tag);
        pop_cmp();
    endtask

    initial begin
        reset = 1'b1;
        sw    = 10'b1111111110;
        #2;
        step(1'b1, "reset");
        step(1'b0, "after_reset");
        // Common year: 110 edges from reset cover every month boundary,
        // the 09->10 carry, the 99->00 wrap and land on count 10.
        for (int i = 2; i <= 110; i++) step(1'b0, "common_run");

        // Leap year: restart and walk to 59 (Feb 29).
        sw[0] = 1'b1;
        step(1'b1, "leap_reset");
        for (int i = 1; i <= 59; i++) step(1'b0, "leap_run");
        set_leap(1'b0, "toggle_common");
        set_leap(1'b1, "toggle_leap");
        set_leap(1'b0, "toggle_common2");
        set_leap(1'b1, "toggle_leap2");
        for (int i = 60; i <= 99; i++) step(1'b0, "leap_run_hi");
        step(1'b0, "leap_wrap");

        // Reset dominates increment mid-run at count 47.
        sw[0] = 1'b0;
        for (int i = 1; i <= 47; i++) step(1'b0, "pre_midreset");
        step(1'b1, "mid_reset");
        step(1'b0, "post_midreset");

        // Upper switches must not disturb anything.
        sw[9:1] = 9'h0AB;
        set_leap(1'b0, "upper_sw");
        step(1'b0, "upper_sw_step");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/day_of_year_date.md
Name: day_of_year_date

Overview:
- Free-running two-digit BCD day counter (00..99) with a combinational day-of-year to calendar-date converter.
- Count N selects day-of-year D = N+1. D is converted to month (MM) and day-of-month (DD), each also split into BCD tens/units digits.
- Serves as the date source for the seven-segment display path. sw[0] selects leap year.

Parameters:
- none

Ports:
- clock  input  1  system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high; forces count to 00
- sw  input  10  switch bank; sw[0]=1 leap year, sw[0]=0 common year; sw[9:1] ignored
- count_msb  output  4  BCD tens digit of count N (0..9)
- count_lsb  output  4  BCD units digit of count N (0..9)
- dd  output  5  day of month, binary (1..31)
- dd_msb  output  4  BCD tens digit of dd (0..3)
- dd_lsb  output  4  BCD units digit of dd (0..9)
- mm  output  4  month, binary (1..4 reachable; 1=Jan)
- mm_msb  output  4  BCD tens digit of month (always 0 in reachable range)

Behaviour:
- Single clock domain. Only count_msb/count_lsb are registered; all other outputs are combinational from the registered count and sw[0].
- Zero latency from count to date outputs: date is valid in the same cycle the count updates.
- Reset is synchronous and active-high. On a rising edge with reset=1, count becomes 00.
- Outputs after reset: dd=1, dd_msb=0, dd_lsb=1, mm=1, mm_msb=0 (Jan 1).
- reset=1 asserted mid-run wins over increment on that edge.
- Counting, with reset=0, every rising edge:
  - count_lsb 0..8: count_lsb += 1.
  - count_lsb = 9: count_lsb becomes 0 and count_msb += 1.
  - 99 wraps to 00. No enable, no saturation.
- Digits never leave 0..9. Any illegal digit (not reachable) is treated as 0 on the next edge.
- Date conversion, with N = 10*count_msb + count_lsb and D = N+1 (1..100):
  - Common year (sw[0]=0):
    - D 1..31 -> mm=1, dd=D.
    - D 32..59 -> mm=2, dd=D-31.
    - D 60..90 -> mm=3, dd=D-59.
    - D 91..100 -> mm=4, dd=D-90.
  - Leap year (sw[0]=1):
    - D 1..31 -> mm=1, dd=D.
    - D 32..60 -> mm=2, dd=D-31.
    - D 61..91 -> mm=3, dd=D-60.
    - D 92..100 -> mm=4, dd=D-91.
- BCD split: dd_msb = dd/10, dd_lsb = dd mod 10. mm_msb = mm/10 (0).
- A change of sw[0] affects the date outputs immediately (combinationally). It never affects the count.
- No X or out-of-range outputs for any count 00..99 and either sw[0] value.

Test Plan:
- Reset: reset=1 for one edge, then release -> count 00, mm=1, dd=1, dd_msb=0, dd_lsb=1. Next edge -> count 01, dd=2.
- Month boundaries, common year (sw[0]=0):
  - count 30 -> Jan 31 (dd_msb=3, dd_lsb=1); count 31 -> Feb 1.
  - count 58 -> Feb 28; count 59 -> Mar 1.
  - count 89 -> Mar 31; count 90 -> Apr 1.
- Leap year (sw[0]=1):
  - count 59 -> Feb 29 (dd_msb=2, dd_lsb=9); count 60 -> Mar 1.
  - count 91 -> Apr 1; count 99 -> Apr 9.
- Wrap: run 110 clocks from reset.
  - count 99 with sw[0]=0 -> Apr 10 (dd_msb=1, dd_lsb=0).
  - Next edge -> count 00, Jan 1. Clock 110 -> count 10, Jan 11.
- BCD carry: count 09 -> next edge count_msb=1, count_lsb=0 (N=10, Jan 11).
- Reset mid-run at count 47 -> next edge count 00, Jan 1. Toggle sw[0] at count 59 -> outputs switch Mar 1 <-> Feb 29 with no clock edge.
